// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller sitting after the PC register.
// It issues one instruction-memory request at a time and steers the PC
// register: sequential PC+4 on each accepted fetch, or the redirect target
// from execute. A one-entry skid buffer absorbs a response that arrives
// while decode is stalled. A redirect squashes everything in flight.
module fetch_ctrl #(
  parameter int LENGTH = 32,
  parameter int ILEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  // PC register interface
  input  logic [LENGTH-1:0] pc_q,
  output logic              pc_wr,
  output logic              pc_sel,
  output logic [LENGTH-1:0] pc_target,
  // redirect from execute
  input  logic              redir_valid,
  input  logic [LENGTH-1:0] redir_addr,
  // instruction memory request / response
  output logic              imem_req_valid,
  output logic [LENGTH-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [ILEN-1:0]   imem_rsp_data,
  // decode interface
  output logic              dec_valid,
  output logic [ILEN-1:0]   dec_instr,
  output logic [LENGTH-1:0] dec_pc,
  input  logic              dec_ready
);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;

  // decode output register
  logic              dec_valid_q, dec_valid_d;
  logic [ILEN-1:0]   dec_instr_q, dec_instr_d;
  logic [LENGTH-1:0] dec_pc_q,    dec_pc_d;

  // one-entry skid buffer
  logic              skid_valid_q, skid_valid_d;
  logic [ILEN-1:0]   skid_instr_q, skid_instr_d;
  logic [LENGTH-1:0] skid_pc_q,    skid_pc_d;

  // PC of the request currently outstanding at memory
  logic [LENGTH-1:0] req_pc_q, req_pc_d;

  // decode handshake and control qualifiers
  logic out_free_s;
  logic redir_act_s;
  logic req_valid_s;
  logic req_fire_s;
  logic rsp_in_wait_s;

  // Qualifiers shared by the FSM, the outputs and the datapath.
  always_comb begin
    // the output register can take a new entry this cycle
    out_free_s    = !dec_valid_q || dec_ready;
    // redirects are honoured only once fetch is running, never under reset
    redir_act_s   = !reset && redir_valid && (state_q != ST_START);
    // a request is offered only from REQ, with room downstream, and not
    // while a redirect is changing the PC underneath it
    req_valid_s   = !reset && (state_q == ST_REQ) && out_free_s && !redir_act_s;
    req_fire_s    = req_valid_s && imem_req_ready;
    rsp_in_wait_s = (state_q == ST_WAIT) && imem_rsp_valid && !redir_act_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a redirect outranks every other event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redir_act_s) begin
          state_d = ST_REQ;
        end else if (req_fire_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redir_act_s) begin
          // a response arriving with the redirect is dropped on the spot;
          // otherwise it is still owed and must be drained
          state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_rsp_valid) begin
          state_d = out_free_s ? ST_REQ : ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redir_act_s || dec_ready) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (redir_act_s) begin
          state_d = ST_DRAIN;
        end else if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // FSM outputs: memory request and PC register control, all zero in reset.
  always_comb begin
    imem_req_valid = req_valid_s;
    if (reset) begin
      imem_req_addr = {LENGTH{1'b0}};
    end else begin
      imem_req_addr = pc_q;
    end
    pc_wr  = redir_act_s || req_fire_s;
    pc_sel = redir_act_s;
    if (redir_act_s) begin
      pc_target = redir_addr;
    end else begin
      pc_target = {LENGTH{1'b0}};
    end
  end

  // Next values of the decode register, skid entry and request PC.
  always_comb begin
    dec_valid_d  = dec_valid_q;
    dec_instr_d  = dec_instr_q;
    dec_pc_d     = dec_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    req_pc_d     = req_pc_q;

    if (redir_act_s) begin
      // squash: nothing fetched on the old path may reach decode, and the
      // decode handshake seen this cycle does not count
      dec_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (dec_valid_q && dec_ready) begin
        dec_valid_d = 1'b0;
      end else begin
        dec_valid_d = dec_valid_q;
      end

      if (rsp_in_wait_s) begin
        if (out_free_s) begin
          dec_valid_d = 1'b1;
          dec_instr_d = imem_rsp_data;
          dec_pc_d    = req_pc_q;
        end else begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_rsp_data;
          skid_pc_d    = req_pc_q;
        end
      end else if ((state_q == ST_HOLD) && dec_ready) begin
        // decode takes the held entry; the skid refills the output slot
        dec_valid_d  = 1'b1;
        dec_instr_d  = skid_instr_q;
        dec_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end

    if (req_fire_s) begin
      req_pc_d = pc_q;
    end else begin
      req_pc_d = req_pc_q;
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid_q  <= 1'b0;
      dec_instr_q  <= {ILEN{1'b0}};
      dec_pc_q     <= {LENGTH{1'b0}};
      skid_valid_q <= 1'b0;
      skid_instr_q <= {ILEN{1'b0}};
      skid_pc_q    <= {LENGTH{1'b0}};
      req_pc_q     <= {LENGTH{1'b0}};
    end else begin
      dec_valid_q  <= dec_valid_d;
      dec_instr_q  <= dec_instr_d;
      dec_pc_q     <= dec_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      req_pc_q     <= req_pc_d;
    end
  end

  // Decode outputs come straight from the output register.
  always_comb begin
    dec_valid = dec_valid_q;
    dec_instr = dec_instr_q;
    dec_pc    = dec_pc_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl. The bench owns the PC register and a simple
// in-order instruction memory, and keeps a program-order model: the fetch
// stream is a sequence of addresses stepping by 4 from the reset PC or the
// latest redirect target, and decode must see exactly that sequence, with
// everything fetched before a redirect or reset thrown away.
module tb_fetch_ctrl;

  localparam int LENGTH = 32;
  localparam int ILEN   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [LENGTH-1:0] pc_q;
  logic              pc_wr;
  logic              pc_sel;
  logic [LENGTH-1:0] pc_target;
  logic              redir_valid;
  logic [LENGTH-1:0] redir_addr;
  logic              imem_req_valid;
  logic [LENGTH-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [ILEN-1:0]   imem_rsp_data;
  logic              dec_valid;
  logic [ILEN-1:0]   dec_instr;
  logic [LENGTH-1:0] dec_pc;
  logic              dec_ready;

  fetch_ctrl #(.LENGTH(LENGTH), .ILEN(ILEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_q           (pc_q),
    .pc_wr          (pc_wr),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .redir_valid    (redir_valid),
    .redir_addr     (redir_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int consumed = 0;

  // bench-side PC register and memory
  logic [31:0] pc_rst;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_lat;

  // program-order model
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic        stale;
  logic        prev_redir;
  logic        prev_reset;

  // values seen in the most recent cycle
  logic        s_reset, s_req_valid, s_req_ready, s_rsp_valid;
  logic        s_pc_wr, s_pc_sel, s_dec_valid;
  logic [31:0] s_req_addr, s_pc_target, s_dec_pc, s_dec_instr;

  // Memory contents: 0x100 -> 0xAAAA0001, 0x104 -> 0xAAAA0002, ...
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [31:0] idx;
    idx = ((a - 32'h100) >> 2) + 32'd1;
    return {16'hAAAA, idx[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample and check at the falling edge, then update the
  // PC register and memory just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    s_reset     = reset;
    s_req_valid = imem_req_valid;
    s_req_ready = imem_req_ready;
    s_req_addr  = imem_req_addr;
    s_rsp_valid = imem_rsp_valid;
    s_pc_wr     = pc_wr;
    s_pc_sel    = pc_sel;
    s_pc_target = pc_target;
    s_dec_valid = dec_valid;
    s_dec_pc    = dec_pc;
    s_dec_instr = dec_instr;

    if (reset) begin
      chk("rst_pc_wr", pc_wr, 32'd0);
      chk("rst_pc_sel", pc_sel, 32'd0);
      chk("rst_pc_target", pc_target, 32'd0);
      chk("rst_req_valid", imem_req_valid, 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'd0);
      exp_q.delete();
      exp_fetch  = pc_rst;
      stale      = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_reset) begin
        chk("rst_dec_valid", dec_valid, 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
      end
      if (redir_valid) begin
        chk("redir_pc_wr", pc_wr, 32'd1);
        chk("redir_pc_sel", pc_sel, 32'd1);
        chk("redir_pc_target", pc_target, redir_addr);
        chk("redir_no_req", imem_req_valid, 32'd0);
        exp_q.delete();
        stale      = mem_busy && !imem_rsp_valid;
        exp_fetch  = redir_addr;
        prev_redir = 1'b1;
      end else begin
        if (prev_redir) chk("post_redir_dec_valid", dec_valid, 32'd0);
        prev_redir = 1'b0;
        chk("seq_pc_sel", pc_sel, 32'd0);
        chk("seq_pc_wr", pc_wr, {31'd0, imem_req_valid && imem_req_ready});
        if (imem_req_valid) begin
          chk("one_outstanding", mem_busy, 32'd0);
          chk("req_addr", imem_req_addr, exp_fetch);
          chk("req_room", {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && dec_ready)}, 32'd1);
        end
        if (dec_valid) begin
          chk("dec_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            chk("dec_pc_order", dec_pc, exp_q[0]);
            chk("dec_instr_data", dec_instr, instr_of(exp_q[0]));
            if (dec_ready) begin
              void'(exp_q.pop_front());
              consumed++;
            end
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          exp_q.push_back(exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (imem_rsp_valid) stale = 1'b0;
      end
    end
    prev_reset = reset;

    @(posedge clk);
    #1;
    // PC register
    if (s_reset) pc_q = pc_rst;
    else if (s_pc_wr) pc_q = s_pc_sel ? s_pc_target : pc_q + 32'd4;
    // memory: one response per accepted request, mem_lat cycles later
    if (s_reset) begin
      mem_busy = 1'b0;
    end else begin
      if (s_rsp_valid) mem_busy = 1'b0;
      if (s_req_valid && s_req_ready) begin
        mem_busy = 1'b1;
        mem_addr = s_req_addr;
        mem_cnt  = mem_lat;
      end
    end
    if (mem_busy && mem_cnt == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (mem_busy) mem_cnt--;
    end
  endtask

  initial begin
    reset          = 1'b1;
    pc_rst         = 32'h100;
    pc_q           = 32'h100;
    redir_valid    = 1'b0;
    redir_addr     = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    dec_ready      = 1'b1;
    mem_busy       = 1'b0;
    mem_addr       = 32'h0;
    mem_cnt        = 0;
    mem_lat        = 1;
    exp_fetch      = 32'h100;
    stale          = 1'b0;
    prev_redir     = 1'b0;
    prev_reset     = 1'b0;

    // ---- sequential fetch from 0x100, one instruction every 2 cycles
    cyc(); cyc();
    reset = 1'b0;
    cyc(); chk("start_idle", s_req_valid, 32'd0);
    cyc(); chk("seq_req0_valid", s_req_valid, 32'd1);
           chk("seq_req0_addr", s_req_addr, 32'h100);
           chk("seq_req0_pc_wr", s_pc_wr, 32'd1);
    cyc(); chk("seq_wait_no_req", s_req_valid, 32'd0);
           chk("seq_wait_dec", s_dec_valid, 32'd0);
    cyc(); chk("seq_dec0_valid", s_dec_valid, 32'd1);
           chk("seq_dec0_pc", s_dec_pc, 32'h100);
           chk("seq_dec0_instr", s_dec_instr, 32'hAAAA0001);
           chk("seq_req1_addr", s_req_addr, 32'h104);
    cyc(); chk("seq_gap", s_dec_valid, 32'd0);
    cyc(); chk("seq_dec1_valid", s_dec_valid, 32'd1);
           chk("seq_dec1_pc", s_dec_pc, 32'h104);
           chk("seq_dec1_instr", s_dec_instr, 32'hAAAA0002);

    // ---- request back-pressure: memory not ready for 3 cycles
    cyc();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("bp_valid_held", s_req_valid, 32'd1);
             chk("bp_addr_stable", s_req_addr, 32'h10C);
             chk("bp_no_pc_wr", s_pc_wr, 32'd0);
    end
    imem_req_ready = 1'b1;
    cyc(); chk("bp_accept_pc_wr", s_pc_wr, 32'd1);
           chk("bp_accept_addr", s_req_addr, 32'h10C);
    cyc();
    cyc(); chk("bp_dec_pc", s_dec_pc, 32'h10C);

    // ---- decode stall holding the instruction at 0x200
    pc_rst = 32'h200;
    reset  = 1'b1;
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("stall_dec_valid", s_dec_valid, 32'd1);
             chk("stall_dec_pc", s_dec_pc, 32'h200);
             chk("stall_dec_instr", s_dec_instr, instr_of(32'h200));
             chk("stall_no_req", s_req_valid, 32'd0);
    end
    dec_ready = 1'b1;
    cyc(); chk("stall_release_req", s_req_valid, 32'd1);
           chk("stall_release_addr", s_req_addr, 32'h204);
    cyc();
    mem_lat = 3;
    cyc(); chk("stall_next_pc", s_dec_pc, 32'h204);
           chk("stall_next_instr", s_dec_instr, instr_of(32'h204));

    // ---- redirect in WAIT with the response still owed
    redir_valid = 1'b1;
    redir_addr  = 32'h400;
    cyc(); chk("rw_pc_wr", s_pc_wr, 32'd1);
           chk("rw_pc_sel", s_pc_sel, 32'd1);
           chk("rw_target", s_pc_target, 32'h400);
    redir_valid = 1'b0;
    cyc(); chk("rw_drain_no_req", s_req_valid, 32'd0);
    cyc(); chk("rw_late_rsp", s_rsp_valid, 32'd1);
           chk("rw_late_no_dec", s_req_valid | s_dec_valid, 32'd0);
    mem_lat = 1;
    cyc(); chk("rw_new_req", s_req_valid, 32'd1);
           chk("rw_new_addr", s_req_addr, 32'h400);
    cyc();
    cyc(); chk("rw_dec_pc", s_dec_pc, 32'h400);

    // ---- redirect together with a response
    redir_valid = 1'b1;
    redir_addr  = 32'h500;
    cyc(); chk("rr_rsp_seen", s_rsp_valid, 32'd1);
    redir_valid = 1'b0;
    cyc(); chk("rr_dec_dropped", s_dec_valid, 32'd0);
           chk("rr_req_addr", s_req_addr, 32'h500);
    cyc();
    cyc(); chk("rr_dec_pc", s_dec_pc, 32'h500);

    // ---- reset in WAIT while the response arrives
    pc_rst = 32'h0;
    reset  = 1'b1;
    cyc(); chk("rm_rsp_seen", s_rsp_valid, 32'd1);
    reset = 1'b0;
    cyc(); chk("rm_no_req", s_req_valid, 32'd0);
           chk("rm_dec_lost", s_dec_valid, 32'd0);
    cyc(); chk("rm_first_req", s_req_valid, 32'd1);
           chk("rm_first_addr", s_req_addr, 32'h0);

    // ---- randomized traffic against the program-order model
    consumed = 0;
    for (int n = 0; n < 3000; n++) begin
      dec_ready      = ($urandom % 4) != 0;
      imem_req_ready = ($urandom % 3) != 0;
      mem_lat        = 1 + int'($urandom % 3);
      redir_valid    = ($urandom % 16) == 0;
      redir_addr     = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cyc();
    end
    redir_valid = 1'b0;
    chk("random_progress", {31'd0, consumed > 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
